// File: rtl/trace_stream_arbiter.sv
// rtl/trace_stream_arbiter.sv - round-robin, packet-locked trace source arbiter with credit flow control
module trace_stream_arbiter #(
    parameter int NUM_SRC    = 4,
    parameter int ID_WIDTH   = 2,
    parameter int DATA_WIDTH = 1024,
    parameter int FIFO_DEPTH = 32,
    parameter int MAX_BURST  = 16
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       enable,
    input  logic [NUM_SRC-1:0]                         src_valid,
    output logic [NUM_SRC-1:0]                         src_ready,
    input  logic [NUM_SRC*(DATA_WIDTH-ID_WIDTH)-1:0]   src_data,
    input  logic [NUM_SRC-1:0]                         src_last,
    output logic                                       out_write_enable,
    output logic [DATA_WIDTH-1:0]                      out_data_pkt,
    output logic                                       out_force_tlast,
    input  logic                                       out_consumed,
    output logic [$clog2(FIFO_DEPTH):0]                credits,
    output logic [ID_WIDTH-1:0]                        grant_id,
    output logic                                       locked,
    output logic                                       credit_err
);

    localparam int SRC_WIDTH = DATA_WIDTH - ID_WIDTH;
    localparam int CREDIT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int BURST_W   = $clog2(MAX_BURST) + 1;

    logic [ID_WIDTH-1:0]  rr_ptr;
    logic [BURST_W-1:0]   burst_cnt;
    logic [ID_WIDTH-1:0]  winner;
    logic                 can_accept;
    logic                 credits_full;
    logic                 credit_inc;
    logic                 xfer;
    logic                 terminate;
    logic [SRC_WIDTH-1:0] payload;

    assign can_accept   = enable & (credits != '0);
    assign credits_full = (credits == CREDIT_W'(FIFO_DEPTH));
    // A consume pulse with nothing outstanding is an error and must not mint a credit.
    assign credit_inc   = out_consumed & ~credits_full;
    assign xfer         = src_valid[winner] & can_accept;
    assign terminate    = src_last[winner] | (burst_cnt == BURST_W'(MAX_BURST - 1));
    assign payload      = src_data[int'(winner)*SRC_WIDTH +: SRC_WIDTH];

    // Pick the winner: the lock holder while a packet is open, else the first valid source after rr_ptr.
    always_comb begin
        logic                found;
        logic [ID_WIDTH-1:0] idx;
        found  = 1'b0;
        idx    = '0;
        winner = ID_WIDTH'((int'(rr_ptr) + 1) % NUM_SRC);
        if (locked) begin
            winner = grant_id;
        end else begin
            for (int k = 1; k <= NUM_SRC; k++) begin
                idx = ID_WIDTH'((int'(rr_ptr) + k) % NUM_SRC);
                if (!found && src_valid[idx]) begin
                    winner = idx;
                    found  = 1'b1;
                end
            end
        end
    end

    // Only the winner ever sees ready, so at most one transfer happens per cycle.
    always_comb begin
        src_ready         = '0;
        src_ready[winner] = can_accept;
    end

    // Register the accepted item into the FIFO write port and track lock, burst and credit state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_write_enable <= 1'b0;
            out_force_tlast  <= 1'b0;
            out_data_pkt     <= '0;
            grant_id         <= '0;
            rr_ptr           <= ID_WIDTH'(NUM_SRC - 1);
            locked           <= 1'b0;
            burst_cnt        <= '0;
            credits          <= CREDIT_W'(FIFO_DEPTH);
            credit_err       <= 1'b0;
        end else begin
            out_write_enable <= xfer;
            out_force_tlast  <= xfer & terminate;
            if (xfer) begin
                out_data_pkt <= {winner, payload};
                grant_id     <= winner;
                rr_ptr       <= winner;
                locked       <= ~terminate;
                burst_cnt    <= terminate ? '0 : burst_cnt + BURST_W'(1);
            end
            if (xfer && !credit_inc) begin
                credits <= credits - CREDIT_W'(1);
            end else if (!xfer && credit_inc) begin
                credits <= credits + CREDIT_W'(1);
            end
            if (out_consumed && credits_full) begin
                credit_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_trace_stream_arbiter.sv
// tb/tb_trace_stream_arbiter.sv - self-checking bench for trace_stream_arbiter
module tb_trace_stream_arbiter;

    localparam int NS    = 4;
    localparam int IDW   = 2;
    localparam int DW    = 1024;
    localparam int SW    = DW - IDW;
    localparam int DEPTH = 32;
    localparam int MB    = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              enable;
    logic [NS-1:0]     src_valid;
    logic [NS-1:0]     src_ready;
    logic [NS*SW-1:0]  src_data;
    logic [NS-1:0]     src_last;
    logic              out_write_enable;
    logic [DW-1:0]     out_data_pkt;
    logic              out_force_tlast;
    logic              out_consumed;
    logic [CW-1:0]     credits;
    logic [IDW-1:0]    grant_id;
    logic              locked;
    logic              credit_err;

    logic [SW-1:0]     pay [NS];
    logic [IDW-1:0]    wr_id [$];
    logic              wr_tl [$];
    logic [DW-1:0]     wr_pkt [$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    genvar g;
    for (g = 0; g < NS; g++) begin : g_pay
        assign src_data[g*SW +: SW] = pay[g];
    end

    trace_stream_arbiter #(
        .NUM_SRC(NS), .ID_WIDTH(IDW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .MAX_BURST(MB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data), .src_last(src_last),
        .out_write_enable(out_write_enable), .out_data_pkt(out_data_pkt),
        .out_force_tlast(out_force_tlast), .out_consumed(out_consumed),
        .credits(credits), .grant_id(grant_id), .locked(locked), .credit_err(credit_err)
    );

    // Record every write seen by the downstream FIFO.
    always @(negedge clk) begin
        if (out_write_enable === 1'b1) begin
            wr_id.push_back(out_data_pkt[DW-1 -: IDW]);
            wr_tl.push_back(out_force_tlast);
            wr_pkt.push_back(out_data_pkt);
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_wr();
        wr_id.delete();
        wr_tl.delete();
        wr_pkt.delete();
    endtask

    task automatic rand_pay();
        for (int i = 0; i < NS; i++) begin
            pay[i] = SW'({$urandom, $urandom, $urandom, $urandom});
            pay[i][SW-1] = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        src_valid = '0;
        src_last = '0;
        out_consumed = 1'b0;
        enable = 1'b1;
        next();
        next();
        rst_n = 1'b1;
        clear_wr();
    endtask

    task automatic test_reset();
        rand_pay();
        rst_n = 1'b0;
        enable = 1'b1;
        src_valid = '1;
        src_last = '1;
        out_consumed = 1'b0;
        next();
        next();
        @(negedge clk);
        checks++; if (credits !== CW'(DEPTH)) begin errors++; $display("FAIL reset_credits got=%0d exp=%0d", credits, DEPTH); end
        checks++; if (out_write_enable !== 1'b0) begin errors++; $display("FAIL reset_we got=%b exp=0", out_write_enable); end
        checks++; if (out_force_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got=%b exp=0", out_force_tlast); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got=%b exp=0", locked); end
        checks++; if (credit_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", credit_err); end
        checks++; if (out_data_pkt !== '0) begin errors++; $display("FAIL reset_data got=%h exp=0", out_data_pkt); end
        checks++; if (grant_id !== '0) begin errors++; $display("FAIL reset_grant got=%0d exp=0", grant_id); end
        next();
        src_valid = '0;
        rst_n = 1'b1;
        next();
    endtask

    task automatic test_round_robin();
        do_reset();
        rand_pay();
        src_valid = 4'b0101;
        src_last = 4'b0101;
        @(negedge clk);
        checks++; if (src_ready !== 4'b0001) begin errors++; $display("FAIL rr_first_ready got=%b exp=0001", src_ready); end
        checks++; if (out_write_enable !== 1'b0) begin errors++; $display("FAIL rr_latency_early got=%b exp=0", out_write_enable); end
        next();
        @(negedge clk);
        checks++; if (out_write_enable !== 1'b1) begin errors++; $display("FAIL rr_latency_one got=%b exp=1", out_write_enable); end
        checks++; if (src_ready !== 4'b0100) begin errors++; $display("FAIL rr_second_ready got=%b exp=0100", src_ready); end
        for (int i = 0; i < 7; i++) next();
        src_valid = '0;
        next();
        next();
        checks++; if (wr_id.size() != 8) begin errors++; $display("FAIL rr_count got=%0d exp=8", wr_id.size()); end
        for (int i = 0; i < wr_id.size() && i < 8; i++) begin
            logic [IDW-1:0] eid;
            eid = (i % 2 == 0) ? IDW'(0) : IDW'(2);
            checks++; if (wr_pkt[i] !== {eid, pay[eid]}) begin errors++; $display("FAIL rr_pkt[%0d] got_id=%0d exp_id=%0d", i, wr_id[i], eid); end
            checks++; if (wr_tl[i] !== 1'b1) begin errors++; $display("FAIL rr_tlast[%0d] got=%b exp=1", i, wr_tl[i]); end
        end
    endtask

    task automatic test_packet_lock();
        logic [IDW-1:0] exp_id [4];
        logic           exp_tl [4];
        exp_id = '{IDW'(1), IDW'(1), IDW'(1), IDW'(3)};
        exp_tl = '{1'b0, 1'b0, 1'b1, 1'b1};
        do_reset();
        rand_pay();
        src_valid = 4'b1010;
        src_last = 4'b1000;
        @(negedge clk);
        checks++; if (src_ready !== 4'b0010) begin errors++; $display("FAIL lock_first_ready got=%b exp=0010", src_ready); end
        next();
        src_valid = 4'b1000;
        @(negedge clk);
        checks++; if (src_ready !== 4'b0010) begin errors++; $display("FAIL lock_idle_ready got=%b exp=0010", src_ready); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_locked got=%b exp=1", locked); end
        next();
        src_valid = 4'b1010;
        next();
        src_last = 4'b1010;
        next();
        src_valid = 4'b1000;
        src_last = 4'b1000;
        next();
        next();
        src_valid = '0;
        next();
        next();
        checks++; if (wr_id.size() != 5) begin errors++; $display("FAIL lock_count got=%0d exp=5", wr_id.size()); end
        for (int i = 0; i < 4 && i < wr_id.size(); i++) begin
            checks++; if (wr_id[i] !== exp_id[i]) begin errors++; $display("FAIL lock_id[%0d] got=%0d exp=%0d", i, wr_id[i], exp_id[i]); end
            checks++; if (wr_tl[i] !== exp_tl[i]) begin errors++; $display("FAIL lock_tlast[%0d] got=%b exp=%b", i, wr_tl[i], exp_tl[i]); end
        end
    endtask

    task automatic test_max_burst();
        do_reset();
        rand_pay();
        src_valid = 4'b0011;
        src_last = 4'b0010;
        for (int i = 0; i < 18; i++) next();
        src_valid = '0;
        next();
        next();
        checks++; if (wr_id.size() != 18) begin errors++; $display("FAIL burst_count got=%0d exp=18", wr_id.size()); end
        for (int i = 0; i < 16 && i < wr_id.size(); i++) begin
            checks++; if (wr_id[i] !== IDW'(0)) begin errors++; $display("FAIL burst_id[%0d] got=%0d exp=0", i, wr_id[i]); end
            checks++; if (wr_tl[i] !== (i == MB - 1)) begin errors++; $display("FAIL burst_tlast[%0d] got=%b exp=%b", i, wr_tl[i], (i == MB - 1)); end
        end
        if (wr_id.size() >= 18) begin
            checks++; if (wr_id[16] !== IDW'(1)) begin errors++; $display("FAIL burst_next_id got=%0d exp=1", wr_id[16]); end
            checks++; if (wr_id[17] !== IDW'(0)) begin errors++; $display("FAIL burst_resume_id got=%0d exp=0", wr_id[17]); end
        end
    endtask

    task automatic test_credit_exhaust();
        do_reset();
        rand_pay();
        src_valid = 4'b0001;
        src_last = 4'b0001;
        for (int i = 0; i < 40; i++) next();
        @(negedge clk);
        checks++; if (wr_id.size() != DEPTH) begin errors++; $display("FAIL exhaust_count got=%0d exp=%0d", wr_id.size(), DEPTH); end
        checks++; if (credits !== '0) begin errors++; $display("FAIL exhaust_credits got=%0d exp=0", credits); end
        checks++; if (src_ready !== '0) begin errors++; $display("FAIL exhaust_ready got=%b exp=0000", src_ready); end
        next();
        out_consumed = 1'b1;
        next();
        out_consumed = 1'b0;
        for (int i = 0; i < 5; i++) next();
        @(negedge clk);
        checks++; if (wr_id.size() != DEPTH + 1) begin errors++; $display("FAIL exhaust_refill got=%0d exp=%0d", wr_id.size(), DEPTH + 1); end
        checks++; if (credits !== '0) begin errors++; $display("FAIL exhaust_credits2 got=%0d exp=0", credits); end
    endtask

    task automatic test_credit_same_cycle();
        do_reset();
        rand_pay();
        src_valid = 4'b0001;
        src_last = 4'b0001;
        for (int i = 0; i < DEPTH - 5; i++) next();
        src_valid = '0;
        next();
        @(negedge clk);
        checks++; if (credits !== CW'(5)) begin errors++; $display("FAIL same_pre got=%0d exp=5", credits); end
        next();
        src_valid = 4'b0001;
        out_consumed = 1'b1;
        next();
        src_valid = '0;
        out_consumed = 1'b0;
        @(negedge clk);
        checks++; if (credits !== CW'(5)) begin errors++; $display("FAIL same_credits got=%0d exp=5", credits); end
        checks++; if (out_write_enable !== 1'b1) begin errors++; $display("FAIL same_we got=%b exp=1", out_write_enable); end
        do_reset();
        next();
        out_consumed = 1'b1;
        next();
        out_consumed = 1'b0;
        @(negedge clk);
        checks++; if (credit_err !== 1'b1) begin errors++; $display("FAIL err_set got=%b exp=1", credit_err); end
        checks++; if (credits !== CW'(DEPTH)) begin errors++; $display("FAIL err_credits got=%0d exp=%0d", credits, DEPTH); end
        for (int i = 0; i < 3; i++) next();
        @(negedge clk);
        checks++; if (credit_err !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b exp=1", credit_err); end
        do_reset();
        @(negedge clk);
        checks++; if (credit_err !== 1'b0) begin errors++; $display("FAIL err_clear got=%b exp=0", credit_err); end
    endtask

    task automatic test_enable();
        do_reset();
        rand_pay();
        enable = 1'b0;
        src_valid = '1;
        src_last = '0;
        for (int i = 0; i < 4; i++) next();
        @(negedge clk);
        checks++; if (src_ready !== '0) begin errors++; $display("FAIL en_ready got=%b exp=0000", src_ready); end
        checks++; if (wr_id.size() != 0) begin errors++; $display("FAIL en_nowrite got=%0d exp=0", wr_id.size()); end
        next();
        enable = 1'b1;
        src_valid = 4'b0001;
        next();
        enable = 1'b0;
        src_valid = 4'b0011;
        @(negedge clk);
        checks++; if (out_write_enable !== 1'b1) begin errors++; $display("FAIL en_inflight got=%b exp=1", out_write_enable); end
        for (int i = 0; i < 3; i++) next();
        @(negedge clk);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL en_lock_held got=%b exp=1", locked); end
        checks++; if (credits !== CW'(DEPTH - 1)) begin errors++; $display("FAIL en_credits_held got=%0d exp=%0d", credits, DEPTH - 1); end
        checks++; if (wr_id.size() != 1) begin errors++; $display("FAIL en_writes got=%0d exp=1", wr_id.size()); end
        next();
        out_consumed = 1'b1;
        next();
        out_consumed = 1'b0;
        @(negedge clk);
        checks++; if (credits !== CW'(DEPTH)) begin errors++; $display("FAIL en_consume got=%0d exp=%0d", credits, DEPTH); end
        next();
        enable = 1'b1;
        @(negedge clk);
        checks++; if (src_ready !== 4'b0001) begin errors++; $display("FAIL en_resume_ready got=%b exp=0001", src_ready); end
        next();
        src_valid = '0;
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        rand_pay();
        src_valid = 4'b0001;
        src_last = 4'b0001;
        for (int i = 0; i < 20; i++) next();
        src_valid = 4'b0010;
        src_last = 4'b0000;
        next();
        next();
        src_valid = '0;
        next();
        @(negedge clk);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL rstmid_locked got=%b exp=1", locked); end
        checks++; if (credits !== CW'(10)) begin errors++; $display("FAIL rstmid_credits got=%0d exp=10", credits); end
        next();
        clear_wr();
        rst_n = 1'b0;
        src_valid = 4'b0010;
        next();
        @(negedge clk);
        checks++; if (out_write_enable !== 1'b0) begin errors++; $display("FAIL rstmid_we got=%b exp=0", out_write_enable); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL rstmid_unlock got=%b exp=0", locked); end
        checks++; if (credits !== CW'(DEPTH)) begin errors++; $display("FAIL rstmid_credits_rst got=%0d exp=%0d", credits, DEPTH); end
        checks++; if (wr_id.size() != 0) begin errors++; $display("FAIL rstmid_nowrite got=%0d exp=0", wr_id.size()); end
        next();
        rst_n = 1'b1;
        src_valid = '1;
        src_last = '1;
        for (int i = 0; i < 4; i++) next();
        src_valid = '0;
        next();
        next();
        checks++; if (wr_id.size() != 4) begin errors++; $display("FAIL rstmid_rr_count got=%0d exp=4", wr_id.size()); end
        for (int i = 0; i < 4 && i < wr_id.size(); i++) begin
            checks++; if (wr_id[i] !== IDW'(i)) begin errors++; $display("FAIL rstmid_rr_id[%0d] got=%0d exp=%0d", i, wr_id[i], i); end
        end
    endtask

    task automatic test_random();
        int             owner, last_srv, plen, occ, win;
        bit             can, xfer, fin;
        logic           m_we, m_tl;
        logic [DW-1:0]  m_pkt;
        logic [IDW-1:0] m_gid, wid;
        logic [NS-1:0]  exp_rdy;
        do_reset();
        owner = -1; last_srv = NS - 1; plen = 0; occ = 0;
        m_we = 1'b0; m_tl = 1'b0; m_pkt = '0; m_gid = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < NS; i++) begin
                src_valid[i] = ($urandom % 4) != 0;
                src_last[i] = ($urandom % 3) == 0;
            end
            rand_pay();
            enable = ($urandom % 10) != 0;
            out_consumed = (occ > 0) && (($urandom % 4) < ((cyc < 1500) ? 2 : 3));
            @(negedge clk);
            win = -1;
            if (owner >= 0) win = owner;
            else for (int k = 1; k <= NS; k++) if (win < 0 && src_valid[(last_srv + k) % NS]) win = (last_srv + k) % NS;
            can = enable && (occ < DEPTH);
            checks++; if (out_write_enable !== m_we) begin errors++; $display("FAIL rnd_we cyc=%0d got=%b exp=%b", cyc, out_write_enable, m_we); end
            if (m_we) begin
                checks++; if (out_data_pkt !== m_pkt) begin errors++; $display("FAIL rnd_pkt cyc=%0d got=%h exp=%h", cyc, out_data_pkt, m_pkt); end
                checks++; if (out_force_tlast !== m_tl) begin errors++; $display("FAIL rnd_tlast cyc=%0d got=%b exp=%b", cyc, out_force_tlast, m_tl); end
            end
            checks++; if (credits !== CW'(DEPTH - occ)) begin errors++; $display("FAIL rnd_credits cyc=%0d got=%0d exp=%0d", cyc, credits, DEPTH - occ); end
            checks++; if (locked !== (owner >= 0)) begin errors++; $display("FAIL rnd_locked cyc=%0d got=%b exp=%b", cyc, locked, owner >= 0); end
            checks++; if (grant_id !== m_gid) begin errors++; $display("FAIL rnd_grant cyc=%0d got=%0d exp=%0d", cyc, grant_id, m_gid); end
            checks++; if (credit_err !== 1'b0) begin errors++; $display("FAIL rnd_err cyc=%0d got=%b exp=0", cyc, credit_err); end
            if (win >= 0) begin
                exp_rdy = '0;
                exp_rdy[win] = can;
                checks++; if (src_ready !== exp_rdy) begin errors++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, src_ready, exp_rdy); end
            end
            xfer = (win >= 0) && src_valid[win] && can;
            m_we = xfer;
            if (xfer) begin
                wid = IDW'(win);
                fin = src_last[win] || (plen + 1 == MB);
                m_pkt = {wid, pay[win]};
                m_tl = fin;
                m_gid = wid;
                last_srv = win;
                if (fin) begin owner = -1; plen = 0; end
                else begin owner = win; plen = plen + 1; end
            end
            occ = occ + (xfer ? 1 : 0) - (out_consumed ? 1 : 0);
            next();
        end
        src_valid = '0;
        out_consumed = 1'b0;
        next();
    endtask

    initial begin
        rst_n = 1'b0;
        enable = 1'b0;
        src_valid = '0;
        src_last = '0;
        out_consumed = 1'b0;
        for (int i = 0; i < NS; i++) pay[i] = '0;
        test_reset();
        test_round_robin();
        test_packet_lock();
        test_max_burst();
        test_credit_exhaust();
        test_credit_same_cycle();
        test_enable();
        test_reset_mid_packet();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/trace_stream_arbiter.md
Name: trace_stream_arbiter

Overview:
Shares one DATA_WIDTH trace-to-AXI-Stream egress path between NUM_SRC independent trace producers. Arbitration is round-robin, and each source's packet stays contiguous until it ends (packet lock). The block tags each item with its source ID and drives the downstream FIFO write port (write_enable, data_pkt, force_tlast). Credit-based flow control against the downstream FIFO depth guarantees the FIFO never overflows.

Parameters:
NUM_SRC, 4, number of requesting trace sources (2..8)
ID_WIDTH, 2, source-ID field width; must equal clog2(NUM_SRC)
DATA_WIDTH, 1024, output item width; source payload width SRC_WIDTH = DATA_WIDTH - ID_WIDTH
FIFO_DEPTH, 32, downstream FIFO depth; initial and maximum credit count
MAX_BURST, 16, maximum items per lock; the item that reaches this count is force-terminated

Ports:
clk  in  1  clock
rst_n  in  1  synchronous, active-low reset
enable  in  1  1 = grants allowed; 0 = no new accepts
src_valid  in  NUM_SRC  per-source item valid
src_ready  out  NUM_SRC  per-source accept (combinational)
src_data  in  NUM_SRC*SRC_WIDTH  payloads; source i occupies bits [i*SRC_WIDTH +: SRC_WIDTH]
src_last  in  NUM_SRC  item ends the packet of that source
out_write_enable  out  1  one-cycle write strobe to downstream FIFO
out_data_pkt  out  DATA_WIDTH  {source ID, payload}; ID in the MSBs
out_force_tlast  out  1  packet end; valid only while out_write_enable=1
out_consumed  in  1  pulse per item leaving the downstream stream (tvalid & tready)
credits  out  clog2(FIFO_DEPTH)+1  free downstream slots
grant_id  out  ID_WIDTH  current/last granted source
locked  out  1  a packet is open on grant_id
credit_err  out  1  sticky; set on out_consumed while credits == FIFO_DEPTH

Behaviour:
- Reset (rst_n=0 at posedge):
  - credits = FIFO_DEPTH; all of out_write_enable, out_force_tlast, locked, credit_err = 0.
  - out_data_pkt = 0, grant_id = 0, RR pointer = NUM_SRC-1, burst counter = 0.
  - Reset mid-packet discards lock and in-flight state; no write is emitted on the reset cycle.
- Accept condition (combinational): can_accept = enable & (credits != 0).
  - Unlocked: winner = first i with src_valid[i]=1, searching from pointer+1 modulo NUM_SRC.
  - Locked: winner = grant_id only, whether or not it is valid. Other sources wait even if the lock holder idles.
  - src_ready is one-hot: src_ready[winner] = can_accept. All other bits are 0.
- Transfer occurs when src_valid[w] & src_ready[w]. On the following cycle (latency 1, registered):
  - out_write_enable = 1.
  - out_data_pkt = {w[ID_WIDTH-1:0], payload}.
  - out_force_tlast = src_last[w] | (burst_cnt == MAX_BURST-1).
  - grant_id = w, pointer = w.
  - Outputs deassert the next cycle unless another transfer occurs; back-to-back transfers give one write per cycle.
- Lock/burst:
  - On transfer with terminate=0: locked = 1, burst_cnt += 1.
  - On transfer with terminate=1: locked = 0, burst_cnt = 0, and the RR pointer advances past w.
  - Single-item packets never lock.
- Credits:
  - Decrement by 1 on transfer; increment by 1 on out_consumed.
  - Both in the same cycle: unchanged.
  - credits == 0 blocks all accepts, including the lock holder.
  - out_consumed while credits == FIFO_DEPTH: credits hold and credit_err sets; it clears only on reset.
- enable=0: no accepts. Lock, burst_cnt and credits are held. A registered write already in flight still emits. out_consumed is still counted.
- All sources idle: no writes; pointer unchanged.

Test Plan:
- Sources 0 and 2 each stream continuously, every item src_last=1 -> writes alternate IDs 0,2,0,2…; out_force_tlast=1 on each; 1-cycle latency from accept.
- Source 1 sends 3-item packet (last on 3rd) while source 3 is valid throughout -> three ID-1 writes contiguous, tlast only on 3rd; source 3 is granted next.
- Source 0 streams 20 items with src_last=0, MAX_BURST=16 -> item 16 has out_force_tlast=1, then lock released; with source 1 also valid, the next write is ID 1.
- No out_consumed pulses, source 0 streams -> exactly 32 writes; credits=0; src_ready=0. One out_consumed pulse -> exactly one more write.
- Transfer and out_consumed in the same cycle at credits=5 -> credits stays 5. out_consumed at credits=32 -> credit_err=1, credits=32.
- rst_n=0 for one cycle while locked mid-packet with credits=10 -> credits=32, locked=0, no write that cycle; round-robin restarts at source 0.
